plc_sequencer: RTL and testbench
================================

# plc_sequencer

Instruction sequencer for the 8-bit PLC core; sits directly upstream of the ALU. Fetches 16-bit instruction words from program memory over a req/ack handshake, drives the ALU opcode, accumulator (in0) and immediate operand (in1), and latches the ALU result back into the accumulator. Runs the program as a cyclic PLC scan: an end-of-scan flag wraps the PC to 0 and pulses `scan_done`.

## Interface
- `PC_W`, 8, program counter / program address width
- `WDT_LIMIT`, 200, max instructions per scan before watchdog fault (used only with `PLC_SEQ_WATCHDOG_EN`)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  level; enables scanning
- `prog_req`  out  1  fetch request
- `prog_addr`  out  PC_W  fetch address
- `prog_ack`  in  1  fetch acknowledge; `prog_data` valid in same cycle
- `prog_data`  in  16  instruction word
- `alu_op`  out  5  to ALU `op`
- `acc`  out  8  accumulator, to ALU `in0`
- `alu_in1`  out  8  immediate operand, to ALU `in1`
- `alu_result`  in  8  from ALU `out`
- `scan_done`  out  1  one-cycle pulse after end-of-scan instruction
- `busy`  out  1  high when not in IDLE
- `wdt_fault`  out  1  sticky watchdog fault

## Operation
- Instruction word: [15:11] op, [10] JZ, [9] EOS, [8] reserved (ignored), [7:0] imm.
- Registers: `pc` (PC_W), `ir` (16), `acc` (8). `alu_op` = ir[15:11], `alu_in1` = ir[7:0], straight from `ir`.
- FSM states IDLE, FETCH, EXEC.
  - IDLE: `prog_req`=0; `run`=1 -> FETCH.
  - FETCH: `prog_req`=1, `prog_addr`=`pc`; on `prog_ack`: `ir`<=`prog_data`, -> EXEC. No ack -> stay.
  - EXEC: ALU sees new `ir` and current `acc`. At edge:
    - `acc`<=`alu_result` if op in {0,1,2,3,4,5,7,8,9,10,13}; all other ops are NOP for `acc`.
    - PC: JZ=1 and `acc`==0 (value before this edge) -> `pc`<=imm[PC_W-1:0]; else EOS=1 -> `pc`<=0, `scan_done`=1 next cycle; else `pc`<=`pc`+1, modulo 2^PC_W.
    - Taken JZ overrides EOS (no wrap, no `scan_done`). The ALU op of a JZ instruction still executes.
    - Next: `run`=1 -> FETCH, else IDLE.
- `run` deassert mid-FETCH: the fetch completes and the instruction executes, then IDLE. A request is never abandoned.
- `prog_ack` outside FETCH is ignored.
- `busy`=1 in FETCH and EXEC.

## Timing
- Reset values: `prog_req` 0, `prog_addr` 0, `alu_op` 0, `alu_in1` 0, `acc` 0, `scan_done` 0, `busy` 0, `wdt_fault` 0. State IDLE, `pc` 0, `ir` 0.
- `rst` overrides all, including mid-handshake: `prog_req` low the cycle after `rst` is sampled.
- `prog_addr` is stable while `prog_req`=1.
- Throughput: with ack in the first FETCH cycle, one instruction per 2 cycles. Each ack wait cycle adds 1.
- `acc` reflects an instruction's result 1 cycle after its EXEC.
- `scan_done` is high for exactly the cycle after the EOS EXEC.

## Configuration
- `PLC_SEQ_WATCHDOG_EN` defined:
  - A counter increments in each EXEC and clears on EOS wrap and on `rst`.
  - If the counter reaches `WDT_LIMIT` in an EXEC whose instruction does not wrap, `wdt_fault`<=1 and the FSM goes to IDLE.
  - The FSM stays in IDLE regardless of `run` until `rst`.
- Not defined: no counter; `wdt_fault` tied 0; `WDT_LIMIT` unused.

## Test plan
- Reset: hold `rst` 2 cycles with `run`=1 -> all outputs 0, `busy`=0. First `prog_req` appears the cycle after `rst` drops.
- Scan with immediate ack: program 0x0005, 0x2803, 0x2208 -> `acc` takes 5, 8, then 0. `scan_done` pulses once. Next `prog_addr`=0. Fetches spaced 2 cycles apart.
- Delayed ack: ack 3 cycles after `prog_req` rises -> `prog_req` held and `prog_addr` constant for 3 cycles. `ir` loads only on the ack cycle.
- JZ: `acc`=0, instruction 0x7410 at addr 1 -> next `prog_addr`=0x10 and `acc` unchanged. Repeat with `acc`=3 -> next `prog_addr`=2.
- NOP and run drop: op 14 (0x7000) with `acc`=0x42 -> `acc` stays 0x42. Drop `run` mid-FETCH -> fetch and EXEC finish, then `busy`=0.
- Watchdog (macro on, `WDT_LIMIT`=4): 8 words of 0x4800, no EOS -> `wdt_fault`=1 after the 4th EXEC, `busy`=0, no further `prog_req`. `rst` clears the fault.

Source files
------------

// File: rtl/plc_sequencer.sv
// plc_sequencer: fetch/execute sequencer feeding the PLC ALU, running the program as a cyclic scan.
// Optional scan watchdog is compiled in when PLC_SEQ_WATCHDOG_EN is defined.
module plc_sequencer #(
    parameter int PC_W      = 8,
    parameter int WDT_LIMIT = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            prog_req,
    output logic [PC_W-1:0] prog_addr,
    input  logic            prog_ack,
    input  logic [15:0]     prog_data,
    output logic [4:0]      alu_op,
    output logic [7:0]      acc,
    output logic [7:0]      alu_in1,
    input  logic [7:0]      alu_result,
    output logic            scan_done,
    output logic            busy,
    output logic            wdt_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [15:0]     r_ir;
    logic [7:0]      r_acc;
    logic            r_scan_done;
    logic            w_jz_taken;
    logic            w_eos_wrap;
    logic            w_acc_wr;
    logic            w_wdt_trip;
    logic            w_wdt_block;
    logic            w_unused_ir;

    // Ops whose ALU result is written back; every other op leaves acc alone.
    function automatic logic op_writes_acc(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
            5'd7, 5'd8, 5'd9, 5'd10, 5'd13: op_writes_acc = 1'b1;
            default:                        op_writes_acc = 1'b0;
        endcase
    endfunction

    // JZ tests the accumulator as it stands before this instruction's write-back.
    assign w_jz_taken  = r_ir[10] && (r_acc == 8'd0);
    assign w_eos_wrap  = r_ir[9] && !w_jz_taken;
    assign w_acc_wr    = op_writes_acc(r_ir[15:11]);
    assign w_unused_ir = r_ir[8];

    always_comb begin
        w_pc_next = r_pc + PC_W'(1);
        if (w_jz_taken) begin
            w_pc_next = PC_W'(r_ir[7:0]);
        end else if (w_eos_wrap) begin
            w_pc_next = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (run && !w_wdt_block) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (prog_ack) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_wdt_trip) begin
                    w_state_next = S_IDLE;
                end else if (run) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_scan_done <= (r_state == S_EXEC) && w_eos_wrap;
            if ((r_state == S_FETCH) && prog_ack) begin
                r_ir <= prog_data;
            end
            if (r_state == S_EXEC) begin
                r_pc <= w_pc_next;
                if (w_acc_wr) begin
                    r_acc <= alu_result;
                end
            end
        end
    end

`ifdef PLC_SEQ_WATCHDOG_EN
    localparam int               WDT_W   = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic [WDT_W-1:0] w_wdt_cnt_inc;
    logic             r_wdt_fault;

    assign w_wdt_cnt_inc = r_wdt_cnt + WDT_W'(1);
    assign w_wdt_trip    = (r_state == S_EXEC) && !w_eos_wrap && (w_wdt_cnt_inc >= WDT_MAX);
    assign w_wdt_block   = r_wdt_fault;
    assign wdt_fault     = r_wdt_fault;

    // Once tripped, the fault holds the FSM in IDLE until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt   <= '0;
            r_wdt_fault <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_wdt_cnt <= w_eos_wrap ? '0 : w_wdt_cnt_inc;
            end
            if (w_wdt_trip) begin
                r_wdt_fault <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (WDT_LIMIT > 0);
    assign w_wdt_trip   = 1'b0;
    assign w_wdt_block  = 1'b0;
    assign wdt_fault    = 1'b0;
`endif

    assign prog_req  = (r_state == S_FETCH);
    assign prog_addr = r_pc;
    assign alu_op    = r_ir[15:11];
    assign alu_in1   = r_ir[7:0];
    assign acc       = r_acc;
    assign scan_done = r_scan_done;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_plc_sequencer.sv
// Scoreboard bench for plc_sequencer: a program-memory responder and a stand-in ALU drive the DUT,
// a reference model pushes expected results at each ack and they are popped after the EXEC edge.
module tb_plc_sequencer;

    localparam int PC_W = 8;
    localparam int WDT  = 4;

    logic            clk;
    logic            rst;
    logic            run;
    logic            prog_req;
    logic [PC_W-1:0] prog_addr;
    logic            prog_ack;
    logic [15:0]     prog_data;
    logic [4:0]      alu_op;
    logic [7:0]      acc;
    logic [7:0]      alu_in1;
    logic [7:0]      alu_result;
    logic            scan_done;
    logic            busy;
    logic            wdt_fault;

    typedef struct {
        logic [7:0] acc;
        logic       scan;
        logic       busy;
        logic       fault;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem [0:255];
    logic [7:0]  m_acc;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    int          m_cnt;
    logic        m_fault;
    int          n_tests;
    int          n_fail;

    plc_sequencer #(.PC_W(PC_W), .WDT_LIMIT(WDT)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .prog_req  (prog_req),
        .prog_addr (prog_addr),
        .prog_ack  (prog_ack),
        .prog_data (prog_data),
        .alu_op    (alu_op),
        .acc       (acc),
        .alu_in1   (alu_in1),
        .alu_result(alu_result),
        .scan_done (scan_done),
        .busy      (busy),
        .wdt_fault (wdt_fault)
    );

    // Stand-in ALU: load, sub, add, increment; anything else gives a scrambled value.
    function automatic logic [7:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            5'd0:    alu_fn = b;
            5'd4:    alu_fn = a - b;
            5'd5:    alu_fn = a + b;
            5'd9:    alu_fn = a + 8'd1;
            default: alu_fn = a ^ b ^ {3'b000, op};
        endcase
    endfunction

    function automatic bit writes_acc(input logic [4:0] op);
        int o;
        o = int'(op);
        writes_acc = (o <= 5) || (o == 7) || (o == 8) || (o == 9) || (o == 10) || (o == 13);
    endfunction

    assign alu_result = alu_fn(alu_op, acc, alu_in1);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc   = 8'd0;
        m_pc    = 8'd0;
        m_ir    = 16'd0;
        m_cnt   = 0;
        m_fault = 1'b0;
        sb_q.delete();
    endtask

    // Serve one fetch: wait for the request, hold off the ack for 'delay' cycles, then score the EXEC.
    task automatic fetch_one(input int delay, input bit drop_run, input int exp_wait);
        int          waited;
        logic [15:0] w;
        logic [7:0]  old_acc;
        bit          jz;
        exp_t        e;
        exp_t        got;
        waited = 0;
        while (prog_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            chk_eq("req_timeout", 32'(waited), 32'(exp_wait));
            return;
        end
        if (exp_wait >= 0) chk_eq("req_latency", 32'(waited), 32'(exp_wait));
        chk_eq("addr", prog_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            if (drop_run && i == 0) run = 1'b0;
            @(negedge clk);
            chk_eq("hold_req", prog_req, 1'b1);
            chk_eq("hold_addr", prog_addr, m_pc);
            chk_eq("ir_hold", {alu_op, alu_in1}, {m_ir[15:11], m_ir[7:0]});
        end
        w         = mem[m_pc];
        prog_ack  = 1'b1;
        prog_data = w;
        old_acc   = m_acc;
        jz        = w[10] && (m_acc == 8'd0);
        e.scan    = w[9] && !jz;
        if (writes_acc(w[15:11])) m_acc = alu_fn(w[15:11], m_acc, w[7:0]);
        if (jz)        m_pc = w[7:0];
        else if (w[9]) m_pc = 8'd0;
        else           m_pc = m_pc + 8'd1;
`ifdef PLC_SEQ_WATCHDOG_EN
        m_cnt++;
        if (e.scan)           m_cnt = 0;
        else if (m_cnt >= WDT) m_fault = 1'b1;
`endif
        e.acc   = m_acc;
        e.busy  = run && !m_fault;
        e.fault = m_fault;
        sb_q.push_back(e);
        m_ir = w;
        @(negedge clk);
        prog_ack  = 1'b0;
        prog_data = 16'($urandom);
        chk_eq("exec_busy", busy, 1'b1);
        chk_eq("exec_req", prog_req, 1'b0);
        chk_eq("exec_ir", {alu_op, alu_in1}, {w[15:11], w[7:0]});
        chk_eq("exec_acc_old", acc, old_acc);
        chk_eq("scan_clear", scan_done, 1'b0);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk_eq("acc", acc, got.acc);
            chk_eq("scan_done", scan_done, got.scan);
            chk_eq("busy", busy, got.busy);
            chk_eq("wdt_fault", wdt_fault, got.fault);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        run       = 1'b1;
        prog_ack  = 1'b0;
        prog_data = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h7000;
        model_reset();

        repeat (2) @(negedge clk);
        chk_eq("rst_req", prog_req, 1'b0);
        chk_eq("rst_addr", prog_addr, 8'd0);
        chk_eq("rst_op", alu_op, 5'd0);
        chk_eq("rst_in1", alu_in1, 8'd0);
        chk_eq("rst_acc", acc, 8'd0);
        chk_eq("rst_scan", scan_done, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_wdt", wdt_fault, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic scan, back-to-back fetches two cycles apart, then wrap to address 0.
        mem[0] = 16'h0005;
        mem[1] = 16'h2803;
        mem[2] = 16'h2208;
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(3, 1'b0, 0);
        fetch_one(0, 1'b0, 0);

        // JZ taken with acc==0, then not taken with acc==3.
        mem[0]    = 16'h7000;
        mem[1]    = 16'h7410;
        mem[8'h10] = 16'h0203;
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(1, 1'b0, 0);

        // Reset in the middle of a pending fetch.
        chk_eq("pre_rst_req", prog_req, 1'b1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_eq("mid_rst_req", prog_req, 1'b0);
        chk_eq("mid_rst_addr", prog_addr, 8'd0);
        chk_eq("mid_rst_acc", acc, 8'd0);
        chk_eq("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Taken JZ overrides EOS, NOP keeps acc, run dropped mid-fetch.
        mem[0]     = 16'h7620;
        mem[8'h20] = 16'h0042;
        mem[8'h21] = 16'h7000;
        mem[8'h22] = 16'h0207;
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(0, 1'b0, 0);
        fetch_one(2, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("idle_req", prog_req, 1'b0);
            chk_eq("idle_busy", busy, 1'b0);
        end
        prog_ack  = 1'b1;
        prog_data = 16'h00FF;
        @(negedge clk);
        prog_ack = 1'b0;
        @(negedge clk);
        chk_eq("stray_ack_acc", acc, 8'h07);
        chk_eq("stray_ack_ir", alu_in1, 8'h07);
        chk_eq("stray_ack_busy", busy, 1'b0);

        // Run without any end-of-scan: watchdog trips in the watchdog build.
        rst = 1'b1;
        run = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) mem[i] = 16'h4800;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef PLC_SEQ_WATCHDOG_EN
        for (int i = 0; i < WDT; i++) fetch_one(0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_eq("wdt_no_req", prog_req, 1'b0);
            chk_eq("wdt_sticky", wdt_fault, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_eq("wdt_rst_clear", wdt_fault, 1'b0);
        rst = 1'b0;
`else
        for (int i = 0; i < 8; i++) fetch_one(0, 1'b0, 0);
        chk_eq("no_wdt_acc", acc, 8'd8);
        chk_eq("no_wdt_fault", wdt_fault, 1'b0);
`endif
        run = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
